// File: rtl/virq_request_unit.sv
// virq_request_unit
// Front end of the vectored interrupt controller. Synchronises 16 raw
// interrupt lines, applies per-source edge or level detection, latches
// edge-mode events in a pending register and presents the request vector
// (gated by ENABLE and, optionally, the in-service mask) to the arbiter.
//
// Build option: define VIRQ_INSERVICE_MASK_EN to add the in-service register
// (set by ack, cleared by EOI). Without it the in-service mask is constant 0
// and the EOI port is ignored.
//
// Config map (cfg_addr): 0=ENABLE, 1=EDGE_MODE, 2=PENDING (read status /
// write-1-to-clear), 3=SW_TRIG (write-1-to-set, reads 0).

module virq_request_unit #(
  parameter int NUM_SRC     = 16,  // arbiter is fixed at 16 sources
  parameter int SYNC_STAGES = 2    // at least 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] cfg_rdata,
  input  logic               ack_valid,
  input  logic [3:0]         ack_num,
  input  logic               eoi_valid,
  input  logic [3:0]         eoi_num,
  output logic [NUM_SRC-1:0] vIRQRequest
);

  localparam logic [1:0] ADDR_ENABLE    = 2'd0;
  localparam logic [1:0] ADDR_EDGE_MODE = 2'd1;
  localparam logic [1:0] ADDR_PENDING   = 2'd2;
  localparam logic [1:0] ADDR_SW_TRIG   = 2'd3;

  // Synchroniser chain: stage 0 samples the raw line, the top stage is s.
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_reg;
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] prev_reg;
  logic [NUM_SRC-1:0] edge_det;

  logic [NUM_SRC-1:0] enable_reg;
  logic [NUM_SRC-1:0] enable_next;
  logic [NUM_SRC-1:0] edge_mode_reg;
  logic [NUM_SRC-1:0] edge_mode_next;
  logic [NUM_SRC-1:0] pend_reg;
  logic [NUM_SRC-1:0] pend_next;
  logic [NUM_SRC-1:0] insvc;

  logic [NUM_SRC-1:0] ack_mask;
  logic [NUM_SRC-1:0] status;
  logic               wr_enable;
  logic               wr_edge_mode;
  logic               wr_pending;
  logic               wr_sw_trig;

  // Shift the raw lines through the synchroniser; reset clears every stage
  // so a line held high through reset yields exactly one rising edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_src};
    end
  end

  assign s        = sync_reg[SYNC_STAGES-1];
  assign edge_det = s & ~prev_reg;

  // Config write decodes and the one-hot ack vector.
  assign wr_enable    = cfg_we && (cfg_addr == ADDR_ENABLE);
  assign wr_edge_mode = cfg_we && (cfg_addr == ADDR_EDGE_MODE);
  assign wr_pending   = cfg_we && (cfg_addr == ADDR_PENDING);
  assign wr_sw_trig   = cfg_we && (cfg_addr == ADDR_SW_TRIG);
  assign ack_mask     = ack_valid ? (NUM_SRC'(1) << ack_num) : '0;

  assign enable_next    = wr_enable    ? cfg_wdata : enable_reg;
  assign edge_mode_next = wr_edge_mode ? cfg_wdata : edge_mode_reg;

  // Per-source pending logic. Set beats clear so a fresh edge is never lost.
  // A bit only lives while the source is in edge mode both now and after
  // this cycle: an edge->level switch drops it, and a level->edge switch
  // starts from 0 (prev already tracks s, so no false edge follows).
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
    logic pend_set;
    logic pend_clr;

    assign pend_set = edge_det[gi] | (wr_sw_trig & cfg_wdata[gi]);
    assign pend_clr = (wr_pending & cfg_wdata[gi]) | ack_mask[gi];
    assign pend_next[gi] = edge_mode_reg[gi] & edge_mode_next[gi] &
                           (pend_set | (pend_reg[gi] & ~pend_clr));
  end

  // Main state: previous synchronised level, config registers and pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg      <= '0;
      enable_reg    <= '0;
      edge_mode_reg <= '0;
      pend_reg      <= '0;
    end else begin
      prev_reg      <= s;
      enable_reg    <= enable_next;
      edge_mode_reg <= edge_mode_next;
      pend_reg      <= pend_next;
    end
  end

`ifdef VIRQ_INSERVICE_MASK_EN
  logic [NUM_SRC-1:0] insvc_reg;
  logic [NUM_SRC-1:0] insvc_next;
  logic [NUM_SRC-1:0] eoi_mask;

  assign eoi_mask = eoi_valid ? (NUM_SRC'(1) << eoi_num) : '0;

  // EOI is applied first and ack last, so an ack and EOI to the same source
  // in one cycle leave it in service. EOI on a clear bit is a no-op.
  always_comb begin
    insvc_next = insvc_reg;
    insvc_next = insvc_next & ~eoi_mask;
    insvc_next = insvc_next | ack_mask;
  end

  // In-service register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      insvc_reg <= '0;
    end else begin
      insvc_reg <= insvc_next;
    end
  end

  assign insvc = insvc_reg;
`else
  // No in-service tracking: EOI is accepted and ignored.
  logic unused_eoi;
  assign unused_eoi = ^{eoi_valid, eoi_num};
  assign insvc      = '0;
`endif

  // Raw per-source status: latched pending for edge sources, live
  // synchronised level for level sources (pend is always 0 for those).
  assign status = (edge_mode_reg & pend_reg) | (~edge_mode_reg & s);

  // Request vector straight from registers, no extra pipeline stage.
  assign vIRQRequest = status & enable_reg & ~insvc;

  // Combinational readback of the addressed register.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:    cfg_rdata = enable_reg;
      ADDR_EDGE_MODE: cfg_rdata = edge_mode_reg;
      ADDR_PENDING:   cfg_rdata = status;
      default:        cfg_rdata = '0;
    endcase
  end

endmodule

// File: doc/virq_request_unit.md
Name: virq_request_unit

Overview:
- Front end of the vectored interrupt controller. Drives the 16-bit vectored request vector that the priority arbiter consumes.
- Synchronises 16 asynchronous interrupt sources and applies per-source edge or level detection.
- Edge-mode sources are held in a pending register; the output is gated by an enable mask and an in-service mask.
- A small config port gives software access; an ack/EOI port lets the CPU-side sequencer retire requests.

Parameters:
- NUM_SRC, 16, number of vectored sources (the arbiter is fixed at 16; other values are unsupported).
- SYNC_STAGES, 2, synchroniser depth per source (minimum 2).

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous active-high reset
- irq_src  in  16  raw asynchronous interrupt lines
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  0=ENABLE, 1=EDGE_MODE, 2=PENDING, 3=SW_TRIG
- cfg_wdata  in  16  config write data
- cfg_rdata  out  16  combinational readback of the register at cfg_addr
- ack_valid  in  1  CPU has taken vectored interrupt ack_num
- ack_num  in  4  source being acknowledged
- eoi_valid  in  1  end of interrupt for eoi_num
- eoi_num  in  4  source being retired
- vIRQRequest  out  16  masked request vector to the arbiter

Behaviour:
- Reset is asynchronous and active-high. On reset, all synchronisers, the previous-level register, ENABLE, EDGE_MODE, the edge-pending register and the in-service register clear to 0. vIRQRequest and cfg_rdata are 0 while rst is high.
- Synchroniser: SYNC_STAGES flops per source; s = last stage; prev = s delayed by one clk.
- Edge detect: edge[i] = s[i] & ~prev[i]. Rising edges only.
- Edge-mode source (EDGE_MODE[i]=1):
  - pend[i] sets on edge[i] or on a SW_TRIG write with bit i=1.
  - pend[i] clears on a PENDING write with bit i=1 (write-1-to-clear), or on ack_valid with ack_num==i.
  - Set beats clear in the same cycle, so a new edge is never lost.
- Level-mode source (EDGE_MODE[i]=0):
  - Request bit = s[i]. No latching.
  - W1C and SW_TRIG have no effect. Ack does not clear the bit.
- Effective request: req[i] = (EDGE_MODE[i] ? pend[i] : s[i]) & ENABLE[i] & ~insvc[i].
- vIRQRequest = req. Purely combinational from registers; no extra stage.
- Latency from an irq_src transition (setup met):
  - Level mode: visible on vIRQRequest after SYNC_STAGES clk edges.
  - Edge mode: visible after SYNC_STAGES+1 clk edges.
- Clearing ENABLE[i] masks the output only. pend[i] is retained and reappears when ENABLE[i] is set again.
- EDGE_MODE write:
  - Bits changing edge->level clear pend[i].
  - Bits changing level->edge start with pend[i]=0. No spurious edge, because prev already tracks s.
- cfg_rdata:
  - addr 0 returns ENABLE; addr 1 returns EDGE_MODE.
  - addr 2 returns the raw status: pend for edge bits, s for level bits, unmasked.
  - addr 3 reads 0.
- Same-cycle accesses:
  - An ack and a W1C on the same bit both clear it.
  - A SW_TRIG write and an edge on the same bit produce a single pend.
- Reset asserted mid-operation drops all pending and in-service state immediately. Sources still high after reset release:
  - Level sources re-request after SYNC_STAGES edges.
  - Edge sources do not re-request until a new rising edge, because the synchroniser and prev come up from 0. A source held high through reset therefore produces one edge.

Optional Feature:
- Macro: VIRQ_INSERVICE_MASK_EN.
- Defined:
  - insvc[ack_num] sets on ack_valid; insvc[eoi_num] clears on eoi_valid.
  - An ack and an EOI to the same number in the same cycle leave the bit set (ack wins).
  - An in-service source is masked from vIRQRequest, but pend still sets.
  - EOI with the bit not set has no effect.
- Not defined: insvc is constant 0, eoi_valid and eoi_num are ignored, and ack only clears pend.

Test Plan:
- Reset, ENABLE=FFFF, EDGE_MODE=0, pulse irq_src[5] high -> vIRQRequest=0x0020 exactly 2 edges later, returns to 0 two edges after irq_src drops.
- EDGE_MODE=FFFF, 1-cycle pulse on irq_src[0] -> vIRQRequest=0x0001 after 3 edges and held; ack_valid with ack_num=0 -> 0x0000 next cycle.
- Edge mode, ENABLE[3]=0, edge on src 3 -> output 0 and PENDING readback 0x0008; set ENABLE[3] -> 0x0008 next cycle; W1C 0x0008 -> 0.
- Same cycle: ack_num=2 and a new synchronised edge on src 2 -> pend[2] remains 1.
- With VIRQ_INSERVICE_MASK_EN: ack src 4 (level, held high) -> output bit 4 drops to 0; eoi_num=4 -> bit 4 reasserts next cycle.
- Assert rst while pend=0x00FF and insvc=0x0001 -> all outputs 0 asynchronously; after release, no request until a new edge.
